// File: rtl/mos6502_interrupt_sequencer.sv
// 6502 interrupt-entry sequencer: arbitrates RESET/NMI/IRQ/BRK at the opcode
// fetch boundary, then walks the address/data path through the six-cycle
// stack-push and vector-fetch microsequence.
module mos6502_interrupt_sequencer #(
   parameter logic [15:0] NMI_VEC = 16'hFFFA,
   parameter logic [15:0] RST_VEC = 16'hFFFC,
   parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
   input  logic        clk,
   input  logic        nRESET,
   input  logic        clk_en,
   input  logic        SYNC,
   input  logic        BRK_op,
   input  logic        nNMI_req,
   input  logic        nIRQ_req,
   output logic        busy,
   output logic        force_brk,
   output logic [1:0]  addr_sel,
   output logic [15:0] vec_addr,
   output logic        RW,
   output logic [1:0]  push_sel,
   output logic        B_flag,
   output logic        sp_dec,
   output logic        pc_inc,
   output logic        load_pcl,
   output logic        load_pch,
   output logic        set_I,
   output logic        nmi_ack,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6} state_t;

   localparam logic [1:0] SRC_RST = 2'd0;
   localparam logic [1:0] SRC_NMI = 2'd1;
   localparam logic [1:0] SRC_IRQ = 2'd2;
   localparam logic [1:0] SRC_BRK = 2'd3;

   localparam logic [1:0] ADDR_PC    = 2'd0;
   localparam logic [1:0] ADDR_STACK = 2'd1;
   localparam logic [1:0] ADDR_VEC   = 2'd2;

   localparam logic [1:0] PUSH_PCH = 2'd0;
   localparam logic [1:0] PUSH_PCL = 2'd1;
   localparam logic [1:0] PUSH_P   = 2'd2;

   state_t      state, state_nxt;
   logic [1:0]  src;
   logic        rst_pend;
   logic        is_brk;    // sequence began as BRK; keeps B set after an NMI hijack
   logic [1:0]  win_src;
   logic        win_valid;
   logic        arb_point;
   logic        hijack;
   logic [15:0] vec_base;

   // Fixed-priority winner among the pending sources
   always_comb begin
      win_src   = SRC_BRK;
      win_valid = 1'b1;
      if (rst_pend)        win_src = SRC_RST;
      else if (!nNMI_req)  win_src = SRC_NMI;
      else if (!nIRQ_req)  win_src = SRC_IRQ;
      else if (BRK_op)     win_src = SRC_BRK;
      else                 win_valid = 1'b0;
   end

   assign arb_point = (state == IDLE) && (rst_pend || SYNC);
   assign hijack    = (state == S1 || state == S2 || state == S3 || state == S4) &&
                      !nNMI_req && (src == SRC_IRQ || src == SRC_BRK);

   // State register; reset aborts any sequence regardless of clk_en
   always_ff @(posedge clk) begin
      if (!nRESET)     state <= IDLE;
      else if (clk_en) state <= state_nxt;
   end

   // Source, pending-reset and BRK-origin tracking
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         src      <= SRC_RST;
         rst_pend <= 1'b1;
         is_brk   <= 1'b0;
      end else if (clk_en) begin
         if (arb_point && win_valid) begin
            src      <= win_src;
            is_brk   <= (win_src == SRC_BRK);
            rst_pend <= 1'b0;
         end else if (hijack) begin
            src <= SRC_NMI;
         end
      end
   end

   // Vector base follows src; src no longer changes once S5 is reached
   always_comb begin
      case (src)
         SRC_RST: vec_base = RST_VEC;
         SRC_NMI: vec_base = NMI_VEC;
         default: vec_base = IRQ_VEC;
      endcase
   end

   assign vec_addr = (state == S6) ? (vec_base | 16'h0001) : vec_base;
   assign busy     = (state != IDLE);

   // Next-state and per-state control decode
   always_comb begin
      state_nxt = state;
      force_brk = 1'b0;
      addr_sel  = ADDR_PC;
      RW        = 1'b1;
      push_sel  = PUSH_PCH;
      B_flag    = 1'b0;
      sp_dec    = 1'b0;
      pc_inc    = 1'b0;
      load_pcl  = 1'b0;
      load_pch  = 1'b0;
      set_I     = 1'b0;
      nmi_ack   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (arb_point && win_valid) state_nxt = S1;
            force_brk = SYNC && !rst_pend && (!nNMI_req || !nIRQ_req);
         end
         S1: begin
            state_nxt = S2;
            pc_inc    = (src == SRC_BRK);
         end
         S2: begin
            state_nxt = S3;
            addr_sel  = ADDR_STACK;
            push_sel  = PUSH_PCH;
            sp_dec    = 1'b1;
            RW        = (src == SRC_RST);
         end
         S3: begin
            state_nxt = S4;
            addr_sel  = ADDR_STACK;
            push_sel  = PUSH_PCL;
            sp_dec    = 1'b1;
            RW        = (src == SRC_RST);
         end
         S4: begin
            state_nxt = S5;
            addr_sel  = ADDR_STACK;
            push_sel  = PUSH_P;
            sp_dec    = 1'b1;
            B_flag    = is_brk;
            RW        = (src == SRC_RST);
         end
         S5: begin
            state_nxt = S6;
            addr_sel  = ADDR_VEC;
            load_pcl  = 1'b1;
            set_I     = 1'b1;
         end
         S6: begin
            state_nxt = IDLE;
            addr_sel  = ADDR_VEC;
            load_pch  = 1'b1;
            done      = 1'b1;
            nmi_ack   = (src == SRC_NMI);
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mos6502_interrupt_sequencer.sv
// Directed bench for the interrupt-entry sequencer: reset entry, IRQ, BRK,
// NMI hijack windows, NMI/IRQ priority, stretched clk_en and mid-sequence reset.
module tb_mos6502_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        nRESET, clk_en, SYNC, BRK_op, nNMI_req, nIRQ_req;
   logic        busy, force_brk, RW, B_flag, sp_dec, pc_inc;
   logic        load_pcl, load_pch, set_I, nmi_ack, done;
   logic [1:0]  addr_sel, push_sel;
   logic [15:0] vec_addr;
   logic [13:0] obs;

   int ntests = 0;
   int nfail  = 0;

   // Output word: busy,addr_sel,RW,push_sel,B,sp_dec,pc_inc,lpcl,lpch,set_I,ack,done
   localparam logic [13:0] O_IDLE = 14'b0_00_1_00_0_0_0_0_0_0_0_0;
   localparam logic [13:0] R_S1   = 14'b1_00_1_00_0_0_0_0_0_0_0_0;
   localparam logic [13:0] R_S2   = 14'b1_01_1_00_0_1_0_0_0_0_0_0;
   localparam logic [13:0] R_S3   = 14'b1_01_1_01_0_1_0_0_0_0_0_0;
   localparam logic [13:0] R_S4   = 14'b1_01_1_10_0_1_0_0_0_0_0_0;
   localparam logic [13:0] W_S2   = 14'b1_01_0_00_0_1_0_0_0_0_0_0;
   localparam logic [13:0] W_S3   = 14'b1_01_0_01_0_1_0_0_0_0_0_0;
   localparam logic [13:0] W_S4   = 14'b1_01_0_10_0_1_0_0_0_0_0_0;
   localparam logic [13:0] B_S1   = 14'b1_00_1_00_0_0_1_0_0_0_0_0;
   localparam logic [13:0] B_S4   = 14'b1_01_0_10_1_1_0_0_0_0_0_0;
   localparam logic [13:0] V_S5   = 14'b1_10_1_00_0_0_0_1_0_1_0_0;
   localparam logic [13:0] V_S6   = 14'b1_10_1_00_0_0_0_0_1_0_0_1;
   localparam logic [13:0] N_S6   = 14'b1_10_1_00_0_0_0_0_1_0_1_1;

   assign obs = {busy, addr_sel, RW, push_sel, B_flag, sp_dec, pc_inc,
                 load_pcl, load_pch, set_I, nmi_ack, done};

   always #5 clk = ~clk;

   mos6502_interrupt_sequencer dut (
      .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .SYNC(SYNC), .BRK_op(BRK_op),
      .nNMI_req(nNMI_req), .nIRQ_req(nIRQ_req), .busy(busy), .force_brk(force_brk),
      .addr_sel(addr_sel), .vec_addr(vec_addr), .RW(RW), .push_sel(push_sel),
      .B_flag(B_flag), .sp_dec(sp_dec), .pc_inc(pc_inc), .load_pcl(load_pcl),
      .load_pch(load_pch), .set_I(set_I), .nmi_ack(nmi_ack), .done(done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [13:0] exp_s [6];
      exp_s = '{R_S1, R_S2, R_S3, R_S4, V_S5, V_S6};
      nRESET = 1'b0; clk_en = 1'b1; SYNC = 1'b0; BRK_op = 1'b0;
      nNMI_req = 1'b1; nIRQ_req = 1'b1;
      step(); step();
      ntests++;
      if (obs !== O_IDLE || force_brk !== 1'b0) begin
         nfail++;
         $display("FAIL reset_state got %b fb=%b want %b fb=0", obs, force_brk, O_IDLE);
      end
      nRESET = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         ntests++;
         if (obs !== exp_s[k]) begin
            nfail++;
            $display("FAIL reset_seq S%0d got %b want %b", k + 1, obs, exp_s[k]);
         end
         if (k == 4 || k == 5) begin
            ntests++;
            if (vec_addr !== ((k == 4) ? 16'hFFFC : 16'hFFFD)) begin
               nfail++;
               $display("FAIL reset_vec S%0d got %h want %h", k + 1, vec_addr,
                        (k == 4) ? 16'hFFFC : 16'hFFFD);
            end
         end
         step();
      end
      ntests++;
      if (obs !== O_IDLE) begin
         nfail++;
         $display("FAIL reset_after got %b want %b", obs, O_IDLE);
      end
   endtask

   task automatic test_irq();
      logic [13:0] exp_s [6];
      exp_s = '{R_S1, W_S2, W_S3, W_S4, V_S5, V_S6};
      SYNC = 1'b1; nIRQ_req = 1'b0;
      #1;
      ntests++;
      if (force_brk !== 1'b1) begin
         nfail++;
         $display("FAIL irq_force_brk got %b want 1", force_brk);
      end
      step();
      SYNC = 1'b0; nIRQ_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ntests++;
         if (obs !== exp_s[k]) begin
            nfail++;
            $display("FAIL irq_seq S%0d got %b want %b", k + 1, obs, exp_s[k]);
         end
         if (k == 4 || k == 5) begin
            ntests++;
            if (vec_addr !== ((k == 4) ? 16'hFFFE : 16'hFFFF)) begin
               nfail++;
               $display("FAIL irq_vec S%0d got %h want %h", k + 1, vec_addr,
                        (k == 4) ? 16'hFFFE : 16'hFFFF);
            end
         end
         step();
      end
   endtask

   task automatic test_brk();
      logic [13:0] exp_s [6];
      exp_s = '{B_S1, W_S2, W_S3, B_S4, V_S5, V_S6};
      SYNC = 1'b1; BRK_op = 1'b1;
      #1;
      ntests++;
      if (force_brk !== 1'b0) begin
         nfail++;
         $display("FAIL brk_force_brk got %b want 0", force_brk);
      end
      step();
      SYNC = 1'b0; BRK_op = 1'b0;
      for (int k = 0; k < 6; k++) begin
         ntests++;
         if (obs !== exp_s[k]) begin
            nfail++;
            $display("FAIL brk_seq S%0d got %b want %b", k + 1, obs, exp_s[k]);
         end
         if (k == 5) begin
            ntests++;
            if (vec_addr !== 16'hFFFF) begin
               nfail++;
               $display("FAIL brk_vec S6 got %h want ffff", vec_addr);
            end
         end
         step();
      end
   endtask

   // nmi_state: index of the state (0=S1) where nNMI_req first goes low
   task automatic test_nmi_hijack(input int nmi_state, input logic hijacked);
      logic [13:0] exp_s [6];
      logic [15:0] v5, v6;
      exp_s = '{B_S1, W_S2, W_S3, B_S4, V_S5, hijacked ? N_S6 : V_S6};
      v5 = hijacked ? 16'hFFFA : 16'hFFFE;
      v6 = hijacked ? 16'hFFFB : 16'hFFFF;
      SYNC = 1'b1; BRK_op = 1'b1;
      step();
      SYNC = 1'b0; BRK_op = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == nmi_state) nNMI_req = 1'b0;
         #1;
         ntests++;
         if (obs !== exp_s[k]) begin
            nfail++;
            $display("FAIL hijack%0d_seq S%0d got %b want %b", nmi_state + 1, k + 1, obs, exp_s[k]);
         end
         if (k == 4 || k == 5) begin
            ntests++;
            if (vec_addr !== ((k == 4) ? v5 : v6)) begin
               nfail++;
               $display("FAIL hijack%0d_vec S%0d got %h want %h", nmi_state + 1, k + 1,
                        vec_addr, (k == 4) ? v5 : v6);
            end
         end
         step();
      end
      nNMI_req = 1'b1;
      #1;
   endtask

   task automatic test_nmi_priority();
      logic [13:0] exp_s [6];
      exp_s = '{R_S1, W_S2, W_S3, W_S4, V_S5, N_S6};
      SYNC = 1'b1; nNMI_req = 1'b0; nIRQ_req = 1'b0;
      #1;
      ntests++;
      if (force_brk !== 1'b1) begin
         nfail++;
         $display("FAIL prio_force_brk got %b want 1", force_brk);
      end
      step();
      SYNC = 1'b0; nNMI_req = 1'b1; nIRQ_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ntests++;
         if (obs !== exp_s[k]) begin
            nfail++;
            $display("FAIL prio_seq S%0d got %b want %b", k + 1, obs, exp_s[k]);
         end
         if (k == 4) begin
            ntests++;
            if (vec_addr !== 16'hFFFA) begin
               nfail++;
               $display("FAIL prio_vec S5 got %h want fffa", vec_addr);
            end
         end
         step();
      end
   endtask

   task automatic test_clk_en_stretch();
      logic [13:0] exp_s [6];
      exp_s = '{R_S1, W_S2, W_S3, W_S4, V_S5, V_S6};
      SYNC = 1'b1; nIRQ_req = 1'b0; clk_en = 1'b1;
      step();
      SYNC = 1'b0; nIRQ_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 3; j++) begin
            clk_en = (j == 2);
            #1;
            ntests++;
            if (obs !== exp_s[k]) begin
               nfail++;
               $display("FAIL stretch_seq S%0d sub%0d got %b want %b", k + 1, j, obs, exp_s[k]);
            end
            step();
         end
      end
      clk_en = 1'b1;
      #1;
      ntests++;
      if (obs !== O_IDLE) begin
         nfail++;
         $display("FAIL stretch_end got %b want %b", obs, O_IDLE);
      end
   endtask

   task automatic test_reset_abort();
      logic [13:0] exp_s [6];
      exp_s = '{R_S1, R_S2, R_S3, R_S4, V_S5, V_S6};
      SYNC = 1'b1; nIRQ_req = 1'b0;
      step();
      SYNC = 1'b0; nIRQ_req = 1'b1;
      step(); step();
      ntests++;
      if (obs !== W_S3) begin
         nfail++;
         $display("FAIL abort_in_s3 got %b want %b", obs, W_S3);
      end
      nRESET = 1'b0; clk_en = 1'b0;
      step();
      ntests++;
      if (obs !== O_IDLE) begin
         nfail++;
         $display("FAIL abort_idle got %b want %b", obs, O_IDLE);
      end
      nRESET = 1'b1; clk_en = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         ntests++;
         if (obs !== exp_s[k]) begin
            nfail++;
            $display("FAIL abort_reset_seq S%0d got %b want %b", k + 1, obs, exp_s[k]);
         end
         if (k == 5) begin
            ntests++;
            if (vec_addr !== 16'hFFFD) begin
               nfail++;
               $display("FAIL abort_reset_vec S6 got %h want fffd", vec_addr);
            end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_irq();
      test_brk();
      test_nmi_hijack(2, 1'b1);
      test_nmi_hijack(4, 1'b0);
      test_nmi_priority();
      test_clk_en_stretch();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
